register_file_clr: RTL and testbench
====================================

Name: register_file_clr

Overview:
- RV32I integer register file. Two asynchronous read ports and one synchronous write port.
- x0 is hardwired to zero. Same-cycle write-to-read bypass is optional.
- A sequential clear engine zeroes x1..x31, one register per cycle, on request.
- Sits between decode (reads) and writeback (write). Drives register_file_intf, and the x0 read-zero properties must hold on every cycle.

Parameters:
- XLEN, 32, data width of each register.
- NUM_REGS, 32, register count; address width is $clog2(NUM_REGS) = 5.
- BYPASS_EN, 1, 1 = a read of the register being written this cycle returns wr_data.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rd_reg_1  in  5  read port 1 address.
- rd_data_1  out  32  read port 1 data (combinational).
- rd_reg_2  in  5  read port 2 address.
- rd_data_2  out  32  read port 2 data (combinational).
- wr_en  in  1  write request.
- wr_reg  in  5  write address.
- wr_data  in  32  write data.
- wr_ready  out  1  write accepted this cycle when wr_en & wr_ready.
- clr_req  in  1  start clear; sampled only in IDLE.
- clr_busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse when the clear completes.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All registers go to 0; state=IDLE; clear pointer=1.
  - Outputs: clr_busy=0, clr_done=0, wr_ready=1.
  - rd_data follows the zeroed array.
  - Deassertion is synchronous to clk in the surrounding reset tree.
- Read:
  - rd_data_n = 0 whenever rd_reg_n==0, regardless of bypass or writes.
  - Otherwise, if BYPASS_EN && wr_en && wr_ready && wr_reg==rd_reg_n && wr_reg!=0, rd_data_n = wr_data.
  - Otherwise rd_data_n = regs[rd_reg_n].
  - Both ports are independent; the same address on both ports returns identical data.
- Write:
  - On posedge clk, if wr_en && wr_ready && wr_reg!=0, then regs[wr_reg] <= wr_data.
  - Writes to x0 are silently dropped.
- FSM states: IDLE, CLEAR, DONE.
  - IDLE: wr_ready=1. If clr_req, go to CLEAR with ptr=1. A write presented in that same cycle still commits, and is erased later by the clear.
  - CLEAR: wr_ready=0, clr_busy=1. Each cycle regs[ptr] <= 0 and ptr <= ptr+1. When ptr==NUM_REGS-1 that register is cleared and the state goes to DONE.
  - DONE: clr_done=1 for exactly one cycle, wr_ready=1, writes accepted. Next state is IDLE.
- clr_req in CLEAR or DONE is ignored and not queued.
- wr_en while wr_ready=0 is dropped. No stall is generated internally; the upstream block must hold.
- Reads during CLEAR return the current array contents. Already-cleared registers read 0; the others keep their old value. There is no bypass during CLEAR.
- Latency:
  - clr_req high at edge k (IDLE) gives clr_busy high over cycles k+1..k+31.
  - clr_done is high in cycle k+32, and the next clr_req can be taken at k+33.
- Reset asserted mid-CLEAR aborts immediately: all registers are zeroed, state returns to IDLE, and no clr_done pulse is produced.
- clr_busy, clr_done and wr_ready are decoded from registered state only.

Test Plan:
- Reset, then read x0..x31 on both ports -> all 0; clr_busy=0, clr_done=0, wr_ready=1.
- Write x5=0xDEADBEEF; next cycle rd_reg_1=5 -> 0xDEADBEEF. Write x0=0x12345678 -> rd_data_2 at x0 stays 0.
- Bypass: wr_en, wr_reg=7, wr_data=0xA5A5A5A5, with rd_reg_1=7 in the same cycle -> rd_data_1=0xA5A5A5A5 combinationally. With BYPASS_EN=0 -> the old value.
- Preload x1..x31 with 0x100+i, then pulse clr_req -> clr_busy high for 31 cycles. After 10 busy cycles x1..x10 read 0 and x11 reads 0x10B. clr_done pulses at cycle 32; all registers then read 0.
- During CLEAR: wr_en to x3 with 0xFFFF_FFFF -> dropped; x3 reads 0 after done. clr_req during CLEAR -> no second sequence.
- Assert rst_n low at busy cycle 15 -> clr_busy=0 immediately, all registers 0, no clr_done pulse. After release, a write is accepted on the first cycle.

Source files
------------

// File: rtl/register_file_clr_if.sv
// Register-file bus: two read ports, one write port and the clear handshake.
// The master side is the pipeline (decode reads, writeback writes); the slave side is
// the register file itself.
interface register_file_clr_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  // Read port 1
  logic [AW-1:0]   rd_reg_1;
  logic [XLEN-1:0] rd_data_1;
  // Read port 2
  logic [AW-1:0]   rd_reg_2;
  logic [XLEN-1:0] rd_data_2;
  // Write port
  logic            wr_en;
  logic [AW-1:0]   wr_reg;
  logic [XLEN-1:0] wr_data;
  logic            wr_ready;
  // Clear engine handshake
  logic            clr_req;
  logic            clr_busy;
  logic            clr_done;

  modport master (
    output rd_reg_1, rd_reg_2, wr_en, wr_reg, wr_data, clr_req,
    input  rd_data_1, rd_data_2, wr_ready, clr_busy, clr_done
  );

  modport slave (
    input  rd_reg_1, rd_reg_2, wr_en, wr_reg, wr_data, clr_req,
    output rd_data_1, rd_data_2, wr_ready, clr_busy, clr_done
  );
endinterface

// File: rtl/register_file_clr.sv
// RV32I integer register file with a sequential clear engine.
// Two combinational read ports, one synchronous write port, x0 hardwired to zero.
// On clr_req (taken only in IDLE) x1..x(NUM_REGS-1) are zeroed one per cycle; writes are
// refused while the engine runs and clr_done pulses for one cycle at the end.
module register_file_clr #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned BYPASS_EN = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  register_file_clr_if.slave  bus
);

  localparam int unsigned AW = $clog2(NUM_REGS);
  localparam logic [AW-1:0] LastReg = AW'(NUM_REGS - 1);
  localparam logic [AW-1:0] FirstReg = AW'(1);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StClear = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   ptr_q;
  logic            busy_q;
  logic            done_q;
  logic            ready_q;

  logic [XLEN-1:0] regs_q [NUM_REGS];

  logic            wr_fire;
  logic            clr_fire;
  logic [XLEN-1:0] rd_data_1;
  logic [XLEN-1:0] rd_data_2;

  // A write commits only when accepted and not aimed at x0.
  assign wr_fire  = bus.wr_en & ready_q & (bus.wr_reg != '0);
  assign clr_fire = (state_q == StClear);

  // Clear sequencer: state, pointer and all handshake outputs are registered together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ptr_q   <= FirstReg;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.clr_req) begin
            state_q <= StClear;
            ptr_q   <= FirstReg;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        StClear: begin
          ptr_q <= ptr_q + AW'(1);
          if (ptr_q == LastReg) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ready_q <= 1'b1;
          end
        end
        StDone: begin
          // clr_req is deliberately ignored here; it is not queued.
          state_q <= StIdle;
          ptr_q   <= FirstReg;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          ptr_q   <= FirstReg;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Storage: writeback port plus the clear engine; they never collide because
  // wr_ready is low for the whole CLEAR state. regs_q[0] is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      if (wr_fire) begin
        regs_q[bus.wr_reg] <= bus.wr_data;
      end
      if (clr_fire) begin
        regs_q[ptr_q] <= '0;
      end
    end
  end

  // Read port 1: x0 forced to zero, then optional same-cycle bypass, then the array.
  always_comb begin
    rd_data_1 = '0;
    if (bus.rd_reg_1 != '0) begin
      if ((BYPASS_EN != 0) && wr_fire && (bus.wr_reg == bus.rd_reg_1)) begin
        rd_data_1 = bus.wr_data;
      end else begin
        rd_data_1 = regs_q[bus.rd_reg_1];
      end
    end
  end

  // Read port 2: identical decode to port 1, fully independent.
  always_comb begin
    rd_data_2 = '0;
    if (bus.rd_reg_2 != '0) begin
      if ((BYPASS_EN != 0) && wr_fire && (bus.wr_reg == bus.rd_reg_2)) begin
        rd_data_2 = bus.wr_data;
      end else begin
        rd_data_2 = regs_q[bus.rd_reg_2];
      end
    end
  end

  assign bus.rd_data_1 = rd_data_1;
  assign bus.rd_data_2 = rd_data_2;
  assign bus.wr_ready  = ready_q;
  assign bus.clr_busy  = busy_q;
  assign bus.clr_done  = done_q;

  // x0 must read zero on both ports every cycle.
  a_x0_port1: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rd_reg_1 == '0) |-> (bus.rd_data_1 == '0));
  a_x0_port2: assert property (@(posedge clk) disable iff (!rst_n)
    (bus.rd_reg_2 == '0) |-> (bus.rd_data_2 == '0));
  // Handshake outputs are mutually consistent.
  a_ready_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    bus.wr_ready == !bus.clr_busy);
  a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
    bus.clr_done |=> !bus.clr_done);

endmodule

// File: tb/tb_register_file_clr.sv
// Scoreboard bench for register_file_clr: a stimulus process predicts each cycle's
// outputs from a behavioural model and queues them; a monitor compares on the negedge.
// A second instance with BYPASS_EN=0 shares the same inputs.
module tb_register_file_clr;
  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  register_file_clr_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) bus ();
  register_file_clr_if #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) bus_nb ();

  assign bus_nb.rd_reg_1 = bus.rd_reg_1;
  assign bus_nb.rd_reg_2 = bus.rd_reg_2;
  assign bus_nb.wr_en    = bus.wr_en;
  assign bus_nb.wr_reg   = bus.wr_reg;
  assign bus_nb.wr_data  = bus.wr_data;
  assign bus_nb.clr_req  = bus.clr_req;

  register_file_clr #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS_EN(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  register_file_clr #(.XLEN(XLEN), .NUM_REGS(NUM_REGS), .BYPASS_EN(0)) dut_nb (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_nb.slave)
  );

  typedef struct {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] rd1_nb;
    logic [31:0] rd2_nb;
    logic        ready;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb_q[$];
  int unsigned tests = 0;
  int unsigned fails = 0;

  // Reference model: architectural contents plus "cycles into the current clear"
  // (0 = no clear, 1..31 = busy cycle number, 32 = done cycle).
  logic [31:0] mem [32];
  int          clr_age;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    clr_age = 0;
  endfunction

  function automatic bit model_ready();
    return (clr_age == 0) || (clr_age == 32);
  endfunction

  function automatic logic [31:0] read_exp(input logic [4:0] a, input bit fire,
                                           input logic [4:0] wr, input logic [31:0] wd,
                                           input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && fire && (wr == a)) return wd;
    return mem[a];
  endfunction

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // One clock cycle of stimulus: drive, predict, then advance the model at the edge.
  task automatic cycle(input bit we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2, input bit cr);
    exp_t e;
    bit   fire;
    bus.wr_en    = we;
    bus.wr_reg   = wr;
    bus.wr_data  = wd;
    bus.rd_reg_1 = r1;
    bus.rd_reg_2 = r2;
    bus.clr_req  = cr;
    fire     = we && model_ready() && (wr != 5'd0);
    e.rd1    = read_exp(r1, fire, wr, wd, 1'b1);
    e.rd2    = read_exp(r2, fire, wr, wd, 1'b1);
    e.rd1_nb = read_exp(r1, fire, wr, wd, 1'b0);
    e.rd2_nb = read_exp(r2, fire, wr, wd, 1'b0);
    e.ready  = model_ready();
    e.busy   = (clr_age >= 1) && (clr_age <= 31);
    e.done   = (clr_age == 32);
    sb_q.push_back(e);
    @(posedge clk);
    if (rst_n) begin
      if (fire) mem[wr] = wd;
      if (clr_age >= 1 && clr_age <= 31) begin
        mem[clr_age] = 32'h0;
        clr_age++;
      end else if (clr_age == 32) begin
        clr_age = 0;
      end else if (cr) begin
        clr_age = 1;
      end
    end
    #1;
  endtask

  task automatic idle_cycle(input logic [4:0] r1, input logic [4:0] r2);
    cycle(1'b0, 5'd0, 32'h0, r1, r2, 1'b0);
  endtask

  task automatic set_reset(input bit v);
    rst_n = v;
    if (!v) model_reset();
  endtask

  task automatic preload();
    for (int i = 1; i < 32; i++) cycle(1'b1, 5'(i), 32'h100 + i, 5'(i - 1), 5'(32 - i), 1'b0);
  endtask

  task automatic random_cycle(input bit allow_reset);
    logic [4:0]  wr;
    logic [4:0]  r1;
    logic [4:0]  r2;
    bit          we;
    bit          cr;
    wr = 5'($urandom);
    r1 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
    r2 = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom);
    we = 1'($urandom_range(0, 1));
    cr = ($urandom_range(0, 40) == 0);
    if (allow_reset && $urandom_range(0, 99) == 0) begin
      set_reset(1'b0);
      idle_cycle(r1, r2);
      set_reset(1'b1);
    end
    cycle(we, wr, $urandom, r1, r2, cr);
  endtask

  // Monitor: compare each queued prediction against both instances.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("rd_data_1", bus.rd_data_1, e.rd1);
        chk("rd_data_2", bus.rd_data_2, e.rd2);
        chk("rd_data_1_nobyp", bus_nb.rd_data_1, e.rd1_nb);
        chk("rd_data_2_nobyp", bus_nb.rd_data_2, e.rd2_nb);
        chk("wr_ready", 32'(bus.wr_ready), 32'(e.ready));
        chk("clr_busy", 32'(bus.clr_busy), 32'(e.busy));
        chk("clr_done", 32'(bus.clr_done), 32'(e.done));
        chk("clr_busy_nobyp", 32'(bus_nb.clr_busy), 32'(e.busy));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.wr_en = 1'b0; bus.wr_reg = '0; bus.wr_data = '0;
    bus.rd_reg_1 = '0; bus.rd_reg_2 = '0; bus.clr_req = 1'b0;
    model_reset();
    #2;
    set_reset(1'b0);
    @(posedge clk); #1;
    idle_cycle(5'd3, 5'd4);
    idle_cycle(5'd0, 5'd31);
    set_reset(1'b1);

    // Everything reads zero out of reset.
    for (int i = 0; i < 32; i++) idle_cycle(5'(i), 5'(31 - i));

    // Basic write/read and dropped x0 write.
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, 1'b0);
    idle_cycle(5'd5, 5'd5);
    cycle(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0);
    idle_cycle(5'd5, 5'd0);

    // Preload, then same-cycle bypass on x7 (no-bypass instance sees 0x107).
    preload();
    cycle(1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 1'b0);
    idle_cycle(5'd7, 5'd11);
    cycle(1'b1, 5'd7, 32'h107, 5'd6, 5'd8, 1'b0);

    // Full clear with a dropped write and an ignored second request.
    cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd31, 1'b1);
    for (int n = 1; n <= 31; n++) begin
      if (n == 11) idle_cycle(5'd10, 5'd11);
      else if (n == 5) cycle(1'b1, 5'd3, 32'hFFFFFFFF, 5'd3, 5'd2, 1'b0);
      else if (n == 8) cycle(1'b0, 5'd0, 32'h0, 5'd7, 5'd8, 1'b1);
      else idle_cycle(5'(n), 5'(n + 1));
    end
    cycle(1'b0, 5'd0, 32'h0, 5'd31, 5'd3, 1'b1);
    for (int i = 0; i < 32; i++) idle_cycle(5'(i), 5'(31 - i));

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) random_cycle(1'b0);

    // Reset in the middle of a clear.
    for (int i = 0; i < 40 && clr_age != 0; i++) idle_cycle(5'd1, 5'd2);
    preload();
    cycle(1'b0, 5'd0, 32'h0, 5'd20, 5'd2, 1'b1);
    for (int n = 1; n <= 14; n++) idle_cycle(5'd20, 5'(n));
    set_reset(1'b0);
    idle_cycle(5'd20, 5'd3);
    idle_cycle(5'd31, 5'd16);
    set_reset(1'b1);
    cycle(1'b1, 5'd9, 32'hCAFEF00D, 5'd9, 5'd20, 1'b0);
    for (int i = 0; i < 20; i++) idle_cycle(5'd9, 5'(i));

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) random_cycle(1'b1);

    @(negedge clk); #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
